// File: rtl/video_dram.sv
// 32K x 8 single-port bitmap video RAM with one-cycle registered read (read-first)
// and an optional post-reset engine that zero-fills the whole array.
module video_dram #(
   parameter int ADDR_W         = 15,
   parameter int DATA_W         = 8,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              init_done
);

   localparam bit CLR_EN = (CLEAR_ON_RESET != 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
   logic              clearing;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wd;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // IDLE already writes location 0 on the first edge after release, so the
   // whole clear takes exactly 2^ADDR_W edges.
   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      clearing     = CLR_EN && (state != ST_READY);
      case (state)
         ST_IDLE: begin
            if (CLR_EN) begin
               state_nxt    = ST_CLEAR;
               clr_addr_nxt = clr_addr + ADDR_W'(1);
            end else begin
               state_nxt = ST_READY;
            end
         end
         ST_CLEAR: begin
            clr_addr_nxt = clr_addr + ADDR_W'(1);
            if (&clr_addr)
               state_nxt = ST_READY;
         end
         ST_READY: ;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_we   = clearing ? 1'b1 : ((state == ST_READY) && we);
      mem_addr = clearing ? clr_addr : addr;
      mem_wd   = clearing ? '0 : din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_addr] <= mem_wd;
   end

   // Read-first: the old contents are captured on the same edge as a write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dout <= '0;
      else if (state == ST_READY)
         dout <= mem[mem_addr];
      else
         dout <= '0;
   end

   assign init_done = (state == ST_READY);

endmodule

// File: tb/tb_video_dram.sv
// Directed bench for video_dram: clear engine, reset abort, latency, read-first,
// interleaved reads, and retention without the clear engine.
module tb_video_dram;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b1;
   logic        we = 1'b0;
   logic [14:0] addr = '0;
   logic [7:0]  din = '0;
   logic [7:0]  dout;
   logic        init_done;

   logic        rst_nc = 1'b1;
   logic        we_nc = 1'b0;
   logic [14:0] addr_nc = '0;
   logic [7:0]  din_nc = '0;
   logic [7:0]  dout_nc;
   logic        done_nc;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   video_dram #(.ADDR_W(15), .DATA_W(8), .CLEAR_ON_RESET(1)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .din(din),
      .dout(dout), .init_done(init_done)
   );

   video_dram #(.ADDR_W(15), .DATA_W(8), .CLEAR_ON_RESET(0)) dut_nc (
      .clk(clk), .rst_n(rst_nc), .we(we_nc), .addr(addr_nc), .din(din_nc),
      .dout(dout_nc), .init_done(done_nc)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [14:0] a, input logic [7:0] d);
      we = 1'b1; addr = a; din = d;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [14:0] a);
      we = 1'b0; addr = a;
      tick();
   endtask

   task automatic wr_nc(input logic [14:0] a, input logic [7:0] d);
      we_nc = 1'b1; addr_nc = a; din_nc = d;
      tick();
      we_nc = 1'b0;
   endtask

   task automatic rd_nc(input logic [14:0] a);
      we_nc = 1'b0; addr_nc = a;
      tick();
   endtask

   // Hammers addr 5 with 0xFF while clearing; counts edges until init_done.
   task automatic wait_clear(input string tag);
      int n;
      bit nz;
      n = 0; nz = 1'b0;
      we = 1'b1; din = 8'hFF; addr = 15'd5;
      while (!init_done && n < 40000) begin
         tick();
         n++;
         if (!init_done && dout !== 8'h00) nz = 1'b1;
      end
      we = 1'b0;
      check({tag, " cycles"}, n, 32768);
      check({tag, " dout held 0"}, {31'd0, nz}, 0);
   endtask

   initial begin
      bit nz;
      #2;
      rst_n = 1'b0; rst_nc = 1'b0;
      #1;
      check("reset dout", dout, 8'h00);
      check("reset init_done", init_done, 0);
      check("nc reset init_done", done_nc, 0);
      @(posedge clk); @(posedge clk); #1;
      we = 1'b1; din = 8'hFF; addr = 15'd5;
      rst_n = 1'b1; rst_nc = 1'b1;
      check("release init_done", init_done, 0);
      check("nc release init_done", done_nc, 0);

      // First clear, aborted by a reset pulse at count 1000.
      nz = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (dout !== 8'h00) nz = 1'b1;
         if (i == 0) check("nc done after 1 edge", done_nc, 1);
      end
      check("clear1a dout held 0", {31'd0, nz}, 0);
      check("clear1a not done", init_done, 0);
      rst_n = 1'b0;
      #1;
      check("abort dout", dout, 8'h00);
      check("abort init_done", init_done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_clear("clear1");
      check("clear1 init_done", init_done, 1);

      rd(15'h0000);  check("clr rd 0000", dout, 8'h00);
      rd(15'h1234);  check("clr rd 1234", dout, 8'h00);
      rd(15'h7FFF);  check("clr rd 7fff", dout, 8'h00);
      rd(15'h0005);  check("clr rd 0005 ignored we", dout, 8'h00);

      // Write/read latency and no combinational path from addr.
      wr(15'h0010, 8'hA5);
      wr(15'h7FFF, 8'h3C);
      addr = 15'h0010;
      #1;
      check("no comb path", dout, 8'h00);
      tick();
      check("rd 0010", dout, 8'hA5);
      rd(15'h7FFF);  check("rd 7fff", dout, 8'h3C);

      // Read-first collision.
      wr(15'h0100, 8'h11);
      we = 1'b1; din = 8'h22; addr = 15'h0100;
      tick();
      check("collision old", dout, 8'h11);
      rd(15'h0100);  check("collision new", dout, 8'h22);

      // Interleaved video/CPU address pattern.
      wr(15'h4000, 8'h5A);
      wr(15'h2001, 8'hC3);
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin addr = 15'h4000; exp_q.push_back(8'h5A); end
         else            begin addr = 15'h2001; exp_q.push_back(8'hC3); end
         we = 1'b0;
         tick();
         check("interleave", dout, exp_q.pop_front());
      end

      // Retention without the clear engine.
      wr_nc(15'h0042, 8'h96);
      rd_nc(15'h0042);  check("nc rd 0042", dout_nc, 8'h96);

      wr(15'h0005, 8'h77);
      rd(15'h0005);  check("rd 0005", dout, 8'h77);

      // Second reset with non-zero outputs; clear must wipe prior writes.
      rd(15'h4000);
      rd_nc(15'h0042);
      rst_n = 1'b0; rst_nc = 1'b0;
      #1;
      check("reset2 dout", dout, 8'h00);
      check("reset2 init_done", init_done, 0);
      check("nc reset2 dout", dout_nc, 8'h00);
      check("nc reset2 init_done", done_nc, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; rst_nc = 1'b1;
      wait_clear("clear2");
      check("nc done after reset2", done_nc, 1);
      rd_nc(15'h0042);  check("nc retained 0042", dout_nc, 8'h96);
      rd(15'h0010);  check("clr2 rd 0010", dout, 8'h00);
      rd(15'h4000);  check("clr2 rd 4000", dout, 8'h00);
      rd(15'h0005);  check("clr2 rd 0005", dout, 8'h00);
      rd(15'h7FFF);  check("clr2 rd 7fff", dout, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
